// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Source encodings match the cdb_src output: 0=RS, 1=BR, 2=SLB.
package cdb_arbiter_pkg;

  localparam int CDB_ENTRY_W = 5;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_NSRC    = 3;

  typedef enum logic [1:0] {
    CDB_SRC_RS  = 2'd0,
    CDB_SRC_BR  = 2'd1,
    CDB_SRC_SLB = 2'd2
  } cdb_src_e;

  // Advance a source index by off positions, modulo the three sources.
  function automatic cdb_src_e cdb_src_step(input cdb_src_e base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return cdb_src_e'(sum[1:0]);
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO for the CDB arbiter: power-of-two depth,
// registered full/empty flags, synchronous flush.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers RS/BR/SLB results and broadcasts one per cycle, round-robin.
// Optional CDB_STATS_EN adds saturating broadcast/stall counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = CDB_ENTRY_W,
  parameter int DATA_W     = CDB_DATA_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               rs_valid,
  input  logic [ENTRY_W-1:0] rs_entry,
  input  logic [DATA_W-1:0]  rs_value,
  input  logic               br_valid,
  input  logic [ENTRY_W-1:0] br_entry,
  input  logic [DATA_W-1:0]  br_value,
  input  logic               slb_valid,
  input  logic [ENTRY_W-1:0] slb_entry,
  input  logic [DATA_W-1:0]  slb_value,
  output logic               rs_full,
  output logic               br_full,
  output logic               slb_full,
  output logic               cdb_valid,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [DATA_W-1:0]  cdb_value,
  output logic [1:0]         cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]        stat_bcast_rs,
  output logic [31:0]        stat_bcast_br,
  output logic [31:0]        stat_bcast_slb,
  output logic [31:0]        stat_stall
`endif
);

  localparam int W = ENTRY_W + DATA_W;

  logic [CDB_NSRC-1:0] src_valid;
  logic [ENTRY_W-1:0]  src_entry [CDB_NSRC];
  logic [W-1:0]        din [CDB_NSRC];
  logic [W-1:0]        head [CDB_NSRC];
  logic [CDB_NSRC-1:0] push, pop, fifo_empty, fifo_full;

  logic                grant_valid;
  cdb_src_e            grant_src;
  logic [W-1:0]        grant_head;
  logic                active;

  cdb_src_e            rr_last_q, rr_last_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ENTRY_W-1:0]  cdb_entry_q, cdb_entry_d;
  logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
  cdb_src_e            cdb_src_q, cdb_src_d;

  assign src_valid = {slb_valid, br_valid, rs_valid};
  assign src_entry[0] = rs_entry;
  assign src_entry[1] = br_entry;
  assign src_entry[2] = slb_entry;
  assign din[0] = {rs_entry, rs_value};
  assign din[1] = {br_entry, br_value};
  assign din[2] = {slb_entry, slb_value};

  // A frozen or flushing cycle neither accepts results nor grants the bus.
  assign active = rdy_in && !clear;

  for (genvar g = 0; g < CDB_NSRC; g++) begin : g_fifo
    cdb_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(W)
    ) u_fifo (
      .clk  (clk_in),
      .rst_n(rst_in),
      .flush(clear),
      .push (push[g]),
      .pop  (pop[g]),
      .din  (din[g]),
      .head (head[g]),
      .empty(fifo_empty[g]),
      .full (fifo_full[g])
    );
  end

  assign rs_full  = fifo_full[0];
  assign br_full  = fifo_full[1];
  assign slb_full = fifo_full[2];

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = CDB_SRC_RS;
    for (int k = 1; k <= CDB_NSRC; k++) begin
      if (!grant_valid && !fifo_empty[cdb_src_step(rr_last_q, 2'(k))]) begin
        grant_valid = 1'b1;
        grant_src   = cdb_src_step(rr_last_q, 2'(k));
      end
    end
    grant_head = head[grant_src];
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < CDB_NSRC; k++) begin
      push[k] = active && src_valid[k] && (src_entry[k] != '0);
      pop[k]  = active && grant_valid && (grant_src == cdb_src_e'(k[1:0]));
    end
  end

  // Entry/value/src are only meaningful while cdb_valid is high, so idle cycles keep them.
  always_comb begin
    rr_last_d   = rr_last_q;
    cdb_valid_d = cdb_valid_q;
    cdb_entry_d = cdb_entry_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    if (clear) begin
      cdb_valid_d = 1'b0;
      rr_last_d   = CDB_SRC_SLB;
    end else if (rdy_in) begin
      cdb_valid_d = grant_valid;
      if (grant_valid) begin
        cdb_entry_d = grant_head[DATA_W +: ENTRY_W];
        cdb_value_d = grant_head[DATA_W-1:0];
        cdb_src_d   = grant_src;
        rr_last_d   = grant_src;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_last_q   <= CDB_SRC_SLB;
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= CDB_SRC_RS;
    end else begin
      rr_last_q   <= rr_last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_entry = cdb_entry_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_STATS_EN
  logic [31:0] stat_bcast_q [CDB_NSRC];
  logic [31:0] stat_bcast_d [CDB_NSRC];
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        multi_pending;

  assign multi_pending = (!fifo_empty[0] && !fifo_empty[1]) ||
                         (!fifo_empty[0] && !fifo_empty[2]) ||
                         (!fifo_empty[1] && !fifo_empty[2]);

  // Counters saturate and survive clear; only reset zeroes them.
  always_comb begin
    for (int k = 0; k < CDB_NSRC; k++) begin
      stat_bcast_d[k] = stat_bcast_q[k];
      if (pop[k] && (stat_bcast_q[k] != '1)) begin
        stat_bcast_d[k] = stat_bcast_q[k] + 32'd1;
      end
    end
    stat_stall_d = stat_stall_q;
    if (active && multi_pending && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < CDB_NSRC; k++) begin
        stat_bcast_q[k] <= '0;
      end
      stat_stall_q <= '0;
    end else begin
      for (int k = 0; k < CDB_NSRC; k++) begin
        stat_bcast_q[k] <= stat_bcast_d[k];
      end
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_bcast_rs  = stat_bcast_q[0];
  assign stat_bcast_br  = stat_bcast_q[1];
  assign stat_bcast_slb = stat_bcast_q[2];
  assign stat_stall     = stat_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcast into a scoreboard, which is compared once the DUT's edge has passed.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        rs_valid = 1'b0, br_valid = 1'b0, slb_valid = 1'b0;
  logic [4:0]  rs_entry = '0, br_entry = '0, slb_entry = '0;
  logic [31:0] rs_value = '0, br_value = '0, slb_value = '0;
  logic        rs_full, br_full, slb_full;
  logic        cdb_valid;
  logic [4:0]  cdb_entry;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  typedef struct packed {
    logic        v;
    logic [4:0]  e;
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  int          n_checks = 0;
  int          n_fails = 0;
  logic [36:0] mq [3][$];
  exp_t        sb [$];
  int          rr = 2;
  logic        m_valid = 1'b0;
  logic [4:0]  m_entry = '0;
  logic [31:0] m_value = '0;
  logic [1:0]  m_src = '0;

  cdb_arbiter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (clear),
    .rs_valid (rs_valid),
    .rs_entry (rs_entry),
    .rs_value (rs_value),
    .br_valid (br_valid),
    .br_entry (br_entry),
    .br_value (br_value),
    .slb_valid(slb_valid),
    .slb_entry(slb_entry),
    .slb_value(slb_value),
    .rs_full  (rs_full),
    .br_full  (br_full),
    .slb_full (slb_full),
    .cdb_valid(cdb_valid),
    .cdb_entry(cdb_entry),
    .cdb_value(cdb_value),
    .cdb_src  (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic doReset();
    rs_valid = 1'b0; br_valid = 1'b0; slb_valid = 1'b0;
    rs_entry = '0; br_entry = '0; slb_entry = '0;
    rdy_in = 1'b1; clear = 1'b0;
    rst_in = 1'b0;
    #2;
    checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
    checkOutput("rst_entry", 64'(cdb_entry), 64'd0);
    checkOutput("rst_value", 64'(cdb_value), 64'd0);
    checkOutput("rst_src", 64'(cdb_src), 64'd0);
    checkOutput("rst_full", 64'({rs_full, br_full, slb_full}), 64'd0);
    for (int k = 0; k < 3; k++) mq[k].delete();
    sb.delete();
    rr = 2;
    m_valid = 1'b0; m_entry = '0; m_value = '0; m_src = '0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [4:0] re, input logic [31:0] rd,
                               input logic bv, input logic [4:0] be, input logic [31:0] bd,
                               input logic sv, input logic [4:0] se, input logic [31:0] sd,
                               input logic rdy, input logic clr);
    logic        v [3];
    logic [4:0]  e [3];
    logic [31:0] d [3];
    logic        m_full [3];
    logic        gv;
    int          g;
    int          c;
    logic [36:0] h;
    exp_t        x;
    exp_t        got;
    v[0] = rv; e[0] = re; d[0] = rd;
    v[1] = bv; e[1] = be; d[1] = bd;
    v[2] = sv; e[2] = se; d[2] = sd;
    for (int k = 0; k < 3; k++) m_full[k] = (mq[k].size() == 4);
    checkOutput("rs_full", 64'(rs_full), 64'(m_full[0]));
    checkOutput("br_full", 64'(br_full), 64'(m_full[1]));
    checkOutput("slb_full", 64'(slb_full), 64'(m_full[2]));
    if (clr) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      rr = 2;
      m_valid = 1'b0;
    end else if (rdy) begin
      gv = 1'b0;
      g = 0;
      for (int off = 1; off <= 3; off++) begin
        c = (rr + off) % 3;
        if (!gv && mq[c].size() > 0) begin
          gv = 1'b1;
          g = c;
        end
      end
      m_valid = gv;
      if (gv) begin
        h = mq[g].pop_front();
        m_entry = h[36:32];
        m_value = h[31:0];
        m_src = 2'(g);
        rr = g;
      end
      for (int k = 0; k < 3; k++) begin
        if (v[k] && e[k] != 5'd0 && !m_full[k]) mq[k].push_back({e[k], d[k]});
      end
    end
    x.v = m_valid; x.e = m_entry; x.d = m_value; x.s = m_src;
    sb.push_back(x);
    rs_valid = rv; rs_entry = re; rs_value = rd;
    br_valid = bv; br_entry = be; br_value = bd;
    slb_valid = sv; slb_entry = se; slb_value = sd;
    rdy_in = rdy; clear = clr;
    @(posedge clk_in);
    #1;
    got = sb.pop_front();
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(got.v));
    if (got.v) begin
      checkOutput("cdb_entry", 64'(cdb_entry), 64'(got.e));
      checkOutput("cdb_value", 64'(cdb_value), 64'(got.d));
      checkOutput("cdb_src", 64'(cdb_src), 64'(got.s));
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic push_all(input int n, input logic [4:0] base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 5'(base + 5'(i)), 32'h100 + 32'(i),
                    1'b1, 5'(base + 5'(i) + 5'd8), 32'h200 + 32'(i),
                    1'b1, 5'(base + 5'(i) + 5'd16), 32'h300 + 32'(i), 1'b1, 1'b0);
    end
  endtask

  initial begin
    doReset();

    $display("[TB] single RS push");
    applyStimulus(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("lat_n0", 64'(cdb_valid), 64'd0);
    run_idle(1);
    checkOutput("lat_entry", 64'({cdb_valid, cdb_entry, cdb_value, cdb_src}), 64'({1'b1, 5'd3, 32'h1234, 2'd0}));
    run_idle(1);
    checkOutput("lat_n2", 64'(cdb_valid), 64'd0);

    $display("[TB] three sources at once");
    applyStimulus(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 5'd4, 32'hC, 1'b1, 1'b0);
    run_idle(4);

    $display("[TB] RS back to back, then RS and BR competing");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 32'h50 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    end
    run_idle(3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 32'h60 + 32'(i), 1'b1, 5'(i + 11), 32'h70 + 32'(i),
                    1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    end
    run_idle(14);

    $display("[TB] clear with queued entries");
    push_all(3, 5'd1);
    applyStimulus(1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd10, 32'hBEEF, 1'b1, 5'd11, 32'hCAFE, 1'b1, 1'b1);
    checkOutput("clr_valid", 64'(cdb_valid), 64'd0);
    run_idle(6);

    $display("[TB] rdy_in low with queued entries");
    push_all(2, 5'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
    end
    run_idle(8);
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hEEEE, 1'b1, 1'b0);
    run_idle(3);

    $display("[TB] reset mid-traffic");
    push_all(3, 5'd3);
    doReset();
    run_idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
    end
    run_idle(14);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
